display_mux_7seg: RTL and testbench

- Downstream consumer of the 4 kHz divider output. Time-multiplexes a 4-digit hexadecimal value onto a common-anode seven-segment display.
- Each rising edge of CLK4kHz advances to the next digit.
- A programmable all-off blanking gap precedes each digit to suppress ghosting.
- The displayed value is latched once per frame so a digit sequence never shows a mix of two values.

---
 rtl/display_mux_7seg_pkg.sv | 32 +++
 rtl/display_mux_7seg_seg7_decoder.sv | 14 +
 rtl/display_mux_7seg.sv | 167 ++++++++++++++++
 tb/tb_display_mux_7seg.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_mux_7seg_pkg.sv
// Shared definitions for the multiplexed seven-segment display driver:
// FSM state encoding and the hex-to-segment lookup table.
package display_mux_7seg_pkg;

  // IDLE: nothing shown since reset; BLANK: anti-ghosting gap; SHOW: digit lit.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  // Active-high segment patterns, bit order {g,f,e,d,c,b,a}, indexed by nibble.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b0111111,  // 0
    7'b0000110,  // 1
    7'b1011011,  // 2
    7'b1001111,  // 3
    7'b1100110,  // 4
    7'b1101101,  // 5
    7'b1111101,  // 6
    7'b0000111,  // 7
    7'b1111111,  // 8
    7'b1101111,  // 9
    7'b1110111,  // A
    7'b1111100,  // b
    7'b0111001,  // C
    7'b1011110,  // d
    7'b1111001,  // E
    7'b1110001   // F
  };

endpackage

// File: rtl/display_mux_7seg_seg7_decoder.sv
// Pure combinational hex nibble to active-high seven-segment pattern.
module seg7_decoder
  import display_mux_7seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  // Straight table lookup; polarity is applied by the caller.
  always_comb begin
    segments = SEG_TABLE[nibble];
  end

endmodule

// File: rtl/display_mux_7seg.sv
// Time-multiplexed common-anode seven-segment driver. Each rising edge of
// CLK4kHz (sampled as data) advances to the next digit after an all-off
// blanking gap. The displayed value is latched once per frame so a frame
// never mixes two values.
module display_mux_7seg
  import display_mux_7seg_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int BLANK_CYCLES = 1000,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                    CLK,
  input  logic                    Reset,
  input  logic                    CLK4kHz,
  input  logic [4*N_DIGITS-1:0]   data_in,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic                    lz_en,
  output logic [N_DIGITS-1:0]     an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done,
  output logic [1:0]              state_dbg
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CNT_W = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BLANK_CYCLES);

  // XOR masks: an "off" raw value of zero becomes the inactive level.
  localparam logic [N_DIGITS-1:0] POL_AN  = {N_DIGITS{ACTIVE_LOW != 0}};
  localparam logic [6:0]          POL_SEG = {7{ACTIVE_LOW != 0}};
  localparam logic                POL_DP  = (ACTIVE_LOW != 0);

  logic                  clk_q;
  logic                  tick;
  state_t                state, state_nxt;
  logic [IDX_W-1:0]      idx, idx_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  latch_frame;
  logic [4*N_DIGITS-1:0] data_s;
  logic [N_DIGITS-1:0]   dp_s;
  logic                  lz_s;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic [N_DIGITS-1:0]   cur_onehot;
  logic [N_DIGITS-1:0]   suppress;
  logic                  zero_run;
  logic                  show_now;
  logic                  digit_on;
  logic [6:0]            dec_seg;

  // Rising-edge detector on the divider output.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) clk_q <= 1'b0;
    else       clk_q <= CLK4kHz;
  end

  assign tick = CLK4kHz & ~clk_q;

  // Next-state logic: ticks are honoured only outside BLANK, never queued.
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    cnt_nxt     = cnt;
    latch_frame = 1'b0;
    case (state)
      ST_IDLE, ST_SHOW: begin
        if (tick) begin
          idx_nxt     = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
          latch_frame = (idx == IDX_LAST);
          cnt_nxt     = CNT_LOAD;
          state_nxt   = ST_BLANK;
        end
      end
      ST_BLANK: begin
        if (cnt == '0) state_nxt = ST_SHOW;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, digit index and blanking counter registers.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state <= ST_IDLE;
      idx   <= IDX_LAST;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Frame shadow registers, captured on the tick that wraps to digit 0.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      data_s     <= '0;
      dp_s       <= '0;
      lz_s       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= latch_frame;
      if (latch_frame) begin
        data_s <= data_in;
        dp_s   <= dp_in;
        lz_s   <= lz_en;
      end
    end
  end

  // Select the nibble, decimal point and anode for the current digit.
  always_comb begin
    cur_nib    = '0;
    cur_dp     = 1'b0;
    cur_onehot = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib       = data_s[4*i +: 4];
        cur_dp        = dp_s[i];
        cur_onehot[i] = 1'b1;
      end
    end
  end

  // Leading-zero mask: digit i is blank when it and every higher nibble are zero.
  always_comb begin
    zero_run = 1'b1;
    suppress = '0;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      zero_run    = zero_run & (data_s[4*i +: 4] == 4'h0);
      suppress[i] = lz_s & zero_run;
    end
  end

  seg7_decoder u_dec (
    .nibble   (cur_nib),
    .segments (dec_seg)
  );

  // The last BLANK cycle already drives the new digit so the gap is exactly
  // BLANK_CYCLES long as seen at the registered outputs.
  assign show_now = (state == ST_SHOW) || ((state == ST_BLANK) && (cnt == '0));
  assign digit_on = show_now && ((suppress & cur_onehot) == '0);

  // Registered, polarity-adjusted display outputs.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      an  <= POL_AN;
      seg <= POL_SEG;
      dp  <= POL_DP;
    end else if (digit_on) begin
      an  <= cur_onehot ^ POL_AN;
      seg <= dec_seg ^ POL_SEG;
      dp  <= cur_dp ^ POL_DP;
    end else begin
      an  <= POL_AN;
      seg <= POL_SEG;
      dp  <= POL_DP;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_display_mux_7seg.sv
// Bench for display_mux_7seg: two instances (4 and 12 blanking cycles)
// compared every cycle against a timeline model of the display.
module tb_display_mux_7seg;
  import display_mux_7seg_pkg::*;

  localparam int N   = 4;
  localparam int B_A = 4;
  localparam int B_B = 12;
  localparam int W   = 13;  // {an[3:0], seg[6:0], dp, frame_done}
  localparam logic [W-1:0] OFF_VEC = {4'hF, 7'h7F, 1'b1, 1'b0};

  localparam logic [6:0] SEG_REF [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  logic        CLK, Reset, c4_a, c4_b;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic        lz_en;
  logic [3:0]  an_a, an_b;
  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b, fd_a, fd_b;
  logic [1:0]  st_a, st_b;

  int total;
  int bad;
  int cyc;
  logic [W-1:0] exp_q_a[$];
  logic [W-1:0] exp_q_b[$];

  typedef struct {
    int          have;
    int          last_k;
    int          idx;
    int          prev_c4;
    logic [15:0] sd;
    logic [3:0]  sdp;
    logic        slz;
    int          on;
    logic [3:0]  an_hi;
    logic [6:0]  seg_hi;
    logic        dp_hi;
  } mdl_t;

  mdl_t m_a, m_b;

  display_mux_7seg #(.N_DIGITS(N), .BLANK_CYCLES(B_A), .ACTIVE_LOW(1)) dut_a (
    .CLK(CLK), .Reset(Reset), .CLK4kHz(c4_a), .data_in(data_in), .dp_in(dp_in),
    .lz_en(lz_en), .an(an_a), .seg(seg_a), .dp(dp_a), .frame_done(fd_a),
    .state_dbg(st_a)
  );

  display_mux_7seg #(.N_DIGITS(N), .BLANK_CYCLES(B_B), .ACTIVE_LOW(1)) dut_b (
    .CLK(CLK), .Reset(Reset), .CLK4kHz(c4_b), .data_in(data_in), .dp_in(dp_in),
    .lz_en(lz_en), .an(an_b), .seg(seg_b), .dp(dp_b), .frame_done(fd_b),
    .state_dbg(st_b)
  );

  // Clock and watchdog.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.have = 0; r.last_k = 0; r.idx = N - 1; r.prev_c4 = 0;
    r.sd = '0; r.sdp = '0; r.slz = 1'b0; r.on = 0;
    r.an_hi = '0; r.seg_hi = '0; r.dp_hi = 1'b0;
    return r;
  endfunction

  // Model view: after an honoured tick at edge k the display is dark from
  // edge k+1 and shows the new digit from edge k+1+b; a tick is honoured only
  // once the previous digit is visible again (edge >= k+b+2) or before any tick.
  function automatic mdl_t mdl_step(input mdl_t m, input int n, input int b, input logic c4,
                                    input logic [15:0] d, input logic [3:0] dpi, input logic lz,
                                    output logic [W-1:0] vec);
    mdl_t r;
    logic [3:0] ea;
    logic [6:0] es;
    logic ed, fd;
    logic [3:0] nib;
    r = m;
    fd = 1'b0;
    if (r.have != 0 && r.on != 0 && n >= r.last_k + b + 1) begin
      ea = ~r.an_hi; es = ~r.seg_hi; ed = ~r.dp_hi;
    end else begin
      ea = 4'hF; es = 7'h7F; ed = 1'b1;
    end
    if (c4 === 1'b1 && r.prev_c4 == 0 && (r.have == 0 || n >= r.last_k + b + 2)) begin
      r.idx = (r.idx + 1) % N;
      if (r.idx == 0) begin
        r.sd = d; r.sdp = dpi; r.slz = lz; fd = 1'b1;
      end
      r.have = 1;
      r.last_k = n;
      nib = 4'((r.sd >> (4 * r.idx)) & 16'hF);
      r.on = (r.slz && r.idx >= 1 && (r.sd >> (4 * r.idx)) == 16'h0) ? 0 : 1;
      r.an_hi = 4'(1 << r.idx);
      r.seg_hi = SEG_REF[nib];
      r.dp_hi = r.sdp[r.idx];
    end
    r.prev_c4 = (c4 === 1'b1) ? 1 : 0;
    vec = {ea, es, ed, fd};
    return r;
  endfunction

  // Reference model: one expected output vector per clock edge.
  always @(posedge CLK or posedge Reset) begin
    logic [W-1:0] va, vb;
    if (Reset) begin
      m_a = mdl_reset();
      m_b = mdl_reset();
      exp_q_a.delete();
      exp_q_b.delete();
      exp_q_a.push_back(OFF_VEC);
      exp_q_b.push_back(OFF_VEC);
    end else begin
      cyc++;
      m_a = mdl_step(m_a, cyc, B_A, c4_a, data_in, dp_in, lz_en, va);
      m_b = mdl_step(m_b, cyc, B_B, c4_b, data_in, dp_in, lz_en, vb);
      exp_q_a.push_back(va);
      exp_q_b.push_back(vb);
    end
  end

  // Scoreboard: compare registered outputs half a cycle after each edge.
  always @(negedge CLK) begin
    logic [W-1:0] v;
    if (exp_q_a.size() > 0) begin
      v = exp_q_a.pop_front();
      check("a_an",  32'(an_a),  32'(v[12:9]));
      check("a_seg", 32'(seg_a), 32'(v[8:2]));
      check("a_dp",  32'(dp_a),  32'(v[1]));
      check("a_fd",  32'(fd_a),  32'(v[0]));
    end
    if (exp_q_b.size() > 0) begin
      v = exp_q_b.pop_front();
      check("b_an",  32'(an_b),  32'(v[12:9]));
      check("b_seg", 32'(seg_b), 32'(v[8:2]));
      check("b_dp",  32'(dp_b),  32'(v[1]));
      check("b_fd",  32'(fd_b),  32'(v[0]));
    end
  end

  task automatic pulse_a(input int hi, input int lo);
    c4_a = 1'b1;
    repeat (hi) @(negedge CLK);
    c4_a = 1'b0;
    repeat (lo) @(negedge CLK);
  endtask

  task automatic pulse_b(input int hi, input int lo);
    c4_b = 1'b1;
    repeat (hi) @(negedge CLK);
    c4_b = 1'b0;
    repeat (lo) @(negedge CLK);
  endtask

  task automatic stim_a();
    logic [15:0] d;
    data_in = 16'h1234; dp_in = 4'b0000; lz_en = 1'b0;
    repeat (8) pulse_a(10, 10);
    // change the value mid-frame while digit 1 is lit
    repeat (2) pulse_a(10, 10);
    data_in = 16'hABCD;
    repeat (6) pulse_a(10, 10);
    lz_en = 1'b1; data_in = 16'h0050;
    repeat (8) pulse_a(10, 10);
    data_in = 16'h0000;
    repeat (8) pulse_a(10, 10);
    lz_en = 1'b0; data_in = 16'h1234; dp_in = 4'b0100;
    repeat (8) pulse_a(10, 10);
    for (int p = 0; p < 60; p++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int j = 0; j < 4; j++)
          d[4*j +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        data_in = d;
        dp_in   = 4'($urandom_range(0, 15));
        lz_en   = 1'($urandom_range(0, 1));
      end
      pulse_a($urandom_range(1, 12), $urandom_range(1, 12));
    end
    // stopped divider: the current digit stays lit
    repeat (40) @(negedge CLK);
  endtask

  task automatic stim_b();
    repeat (6) pulse_b(10, 10);
    // second rising edge three cycles into the blanking gap
    c4_b = 1'b1;
    @(negedge CLK);
    c4_b = 1'b0;
    repeat (2) @(negedge CLK);
    c4_b = 1'b1;
    repeat (10) @(negedge CLK);
    c4_b = 1'b0;
    repeat (10) @(negedge CLK);
    repeat (4) pulse_b(10, 10);
  endtask

  initial begin
    int found;
    total = 0; bad = 0; cyc = 0;
    Reset = 1'b1; c4_a = 1'b0; c4_b = 1'b0;
    data_in = 16'h0; dp_in = 4'h0; lz_en = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_an",    32'(an_a),  32'(4'hF));
    check("rst_seg",   32'(seg_a), 32'(7'h7F));
    check("rst_dp",    32'(dp_a),  32'(1'b1));
    check("rst_fd",    32'(fd_a),  32'(1'b0));
    check("rst_state", 32'(st_a),  32'(ST_IDLE));
    check("rst_state_b", 32'(st_b), 32'(ST_IDLE));
    Reset = 1'b0;
    repeat (5) @(negedge CLK);

    fork
      stim_a();
      stim_b();
    join

    // asynchronous reset while a digit is lit, between clock edges
    data_in = 16'h1234; dp_in = 4'h0; lz_en = 1'b0;
    repeat (3) pulse_a(10, 10);
    found = 0;
    for (int i = 0; i < 50 && found == 0; i++) begin
      @(negedge CLK);
      if (an_a != 4'hF) found = 1;
    end
    check("wait_show", 32'(found), 32'(1));
    #2 Reset = 1'b1;
    #1;
    check("mid_rst_an",  32'(an_a),  32'(4'hF));
    check("mid_rst_seg", 32'(seg_a), 32'(7'h7F));
    check("mid_rst_dp",  32'(dp_a),  32'(1'b1));
    check("mid_rst_fd",  32'(fd_a),  32'(1'b0));
    @(negedge CLK);
    Reset = 1'b0;
    repeat (15) @(negedge CLK);
    repeat (5) pulse_a(10, 10);
    repeat (5) @(negedge CLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
